// File: rtl/sram_req_shim.sv
// Request/response shim between a valid/ready port and a fixed-latency single-port SRAM.
// Optional out-of-range address checking is enabled with `define SRAM_REQ_SHIM_ADDR_CHECK_EN.
module sram_req_shim #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int unsigned Depth     = Latency + 1,
  localparam int unsigned CntWidth  = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,

  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,

  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  logic                 fire;
  logic                 rd_fire;
  logic                 fwd;
  logic                 addr_ok;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic [DataWidth-1:0] push_data;

  logic [Latency-1:0]   inflight_q, inflight_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [CntWidth-1:0]  occ_q, occ_d;
  logic [PtrWidth-1:0]  wptr_q, wptr_d;
  logic [PtrWidth-1:0]  rptr_q, rptr_d;
  logic [DataWidth-1:0] fifo_data_q [Depth];

`ifdef SRAM_REQ_SHIM_ADDR_CHECK_EN
  logic [Latency-1:0]   inflight_err_q, inflight_err_d;
  logic                 fifo_err_q [Depth];
  logic                 push_err;

  assign addr_ok = ({1'b0, req_addr_i} < (AddrWidth + 1)'(NumWords));
`else
  assign addr_ok = 1'b1;
`endif

  // Request side: credit-based acceptance, reset forces ready low.
  assign rsp_valid_o = (occ_q != '0);
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign req_ready_o = ~rst_i & ((cnt_q < CntWidth'(Depth)) | pop);
  assign fire        = req_valid_i & req_ready_o;
  assign rd_fire     = fire & ~req_we_i;
  assign fwd         = fire & addr_ok;

  assign sram_req_o   = fwd;
  assign sram_we_o    = fwd & req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  assign push = inflight_q[Latency-1];
  assign full = (occ_q == CntWidth'(Depth));

`ifdef SRAM_REQ_SHIM_ADDR_CHECK_EN
  assign push_err  = inflight_err_q[Latency-1];
  assign push_data = push_err ? '0 : sram_rdata_i;
`else
  assign push_data = sram_rdata_i;
`endif

  always_comb begin
    inflight_d = Latency'({inflight_q, rd_fire});
`ifdef SRAM_REQ_SHIM_ADDR_CHECK_EN
    inflight_err_d = Latency'({inflight_err_q, rd_fire & ~addr_ok});
`endif

    cnt_d = cnt_q;
    case ({rd_fire, pop})
      2'b10:   cnt_d = cnt_q + CntWidth'(1);
      2'b01:   cnt_d = cnt_q - CntWidth'(1);
      default: cnt_d = cnt_q;
    endcase

    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + CntWidth'(1);
      2'b01:   occ_d = occ_q - CntWidth'(1);
      default: occ_d = occ_q;
    endcase

    // Depth need not be a power of two, so pointers wrap explicitly.
    wptr_d = wptr_q;
    if (push) begin
      wptr_d = (wptr_q == PtrWidth'(Depth - 1)) ? '0 : wptr_q + PtrWidth'(1);
    end
    rptr_d = rptr_q;
    if (pop) begin
      rptr_d = (rptr_q == PtrWidth'(Depth - 1)) ? '0 : rptr_q + PtrWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= '0;
      cnt_q      <= '0;
      occ_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      occ_q      <= occ_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wptr_q] <= push_data;
    end
  end

  assign rsp_rdata_o = rsp_valid_o ? fifo_data_q[rptr_q] : '0;

`ifdef SRAM_REQ_SHIM_ADDR_CHECK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_err_q <= '0;
    end else begin
      inflight_err_q <= inflight_err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_err_q[wptr_q] <= push_err;
    end
  end

  assign rsp_err_o = rsp_valid_o & fifo_err_q[rptr_q];
`else
  assign rsp_err_o = 1'b0;
`endif

  // Credits bound in-flight reads plus occupancy, so a full FIFO never sees a lone push.
  assert property (@(posedge clk_i) disable iff (rst_i) !(push && full && !pop));

endmodule

// File: doc/sram_req_shim.md
SRAM_REQ_SHIM -- requirements
Module: sram_req_shim

Interface
REQ-001 SHALL have parameter NumWords, default 1024, number of SRAM words.
REQ-002 SHALL have parameter DataWidth, default 64, data width in bits.
REQ-003 SHALL have parameter ByteWidth, default 8, bits per byte enable.
REQ-004 SHALL have parameter Latency, default 1, downstream SRAM read latency in cycles; legal range 1..4.
REQ-005 SHALL derive AddrWidth = max(1, clog2(NumWords)), BeWidth = ceil(DataWidth/ByteWidth), Depth = Latency+1 and CntWidth = clog2(Depth+1).
REQ-006 SHALL have one clock; reset is asynchronous and active-high.
REQ-007 clk_i  in  1  sole clock, all state on rising edge.
REQ-008 rst_i  in  1  asynchronous active-high reset.
REQ-009 req_valid_i  in  1 / req_ready_o  out  1  upstream request handshake.
REQ-010 req_we_i  in  1 / req_addr_i  in  AddrWidth / req_wdata_i  in  DataWidth / req_be_i  in  BeWidth  request payload.
REQ-011 rsp_valid_o  out  1 / rsp_ready_i  in  1 / rsp_rdata_o  out  DataWidth / rsp_err_o  out  1  read-response handshake and payload.
REQ-012 sram_req_o, sram_we_o  out  1 / sram_addr_o  out  AddrWidth / sram_wdata_o  out  DataWidth / sram_be_o  out  BeWidth  single-port SRAM request.
REQ-013 sram_rdata_i  in  DataWidth  SRAM read data, valid exactly Latency cycles after a read request.

Function
REQ-014 Handshake SHALL fire when req_valid_i & req_ready_o; payload SHALL be stable while valid and not ready.
REQ-015 A fired request SHALL drive sram_req_o=1 combinationally in the same cycle, with sram_we_o/addr/wdata/be equal to the request payload; otherwise sram_req_o=0 and sram_we_o=0.
REQ-016 Writes SHALL be posted: no response is generated.
REQ-017 Each fired read SHALL set bit 0 of a Latency-bit in-flight shift register; bit Latency-1 set SHALL push sram_rdata_i (and its error flag) into a response FIFO of Depth entries.
REQ-018 rsp_valid_o SHALL equal FIFO non-empty and rsp_rdata_o/rsp_err_o SHALL present the FIFO head; read-to-response latency is Latency+1 cycles, no bypass.
REQ-019 Credit counter cnt (CntWidth bits) SHALL count in-flight reads plus FIFO occupancy: +1 on fired read, -1 on response pop, unchanged when both or neither occur.
REQ-020 req_ready_o SHALL be (cnt < Depth) | (rsp_valid_o & rsp_ready_i), for both reads and writes.
REQ-021 FIFO SHALL never overflow; push while full SHALL be impossible by construction (assertion in simulation).
REQ-022 FIFO pointers SHALL wrap modulo Depth; simultaneous push and pop on a full or empty FIFO SHALL keep occupancy unchanged and order preserved.
REQ-023 With rsp_ready_i held 1, back-to-back reads SHALL sustain one request per cycle.

Reset
REQ-024 rst_i assertion SHALL immediately clear cnt, in-flight register, FIFO pointers and occupancy.
REQ-025 During reset outputs SHALL be req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, sram_req_o=0.
REQ-026 Reads in flight at reset SHALL be discarded; no response SHALL appear after deassertion.

Configuration
REQ-027 Macro SRAM_REQ_SHIM_ADDR_CHECK_EN defined: a request with req_addr_i >= NumWords SHALL fire normally but SHALL NOT assert sram_req_o; a read SHALL return rsp_rdata_o=0, rsp_err_o=1 with unchanged latency; a write SHALL be dropped.
REQ-028 Macro undefined: all requests SHALL be forwarded and rsp_err_o SHALL be tied 0.

Verification
REQ-029 Latency=2: read addr 0x10 (SRAM holds 0xA5) at cycle 0, rsp_ready_i=1 -> rsp_valid_o=1, rsp_rdata_o=0xA5 at cycle 3.
REQ-030 Latency=2, rsp_ready_i=0, continuous reads -> exactly 3 fire, req_ready_o=0 afterwards; raising rsp_ready_i -> req_ready_o=1 same cycle, 3 responses in order.
REQ-031 Write addr 5 data 0x1234 be all ones, then read addr 5 -> one response only, data 0x1234.
REQ-032 rsp_ready_i=1, 16 back-to-back reads -> 16 fires in 16 cycles, responses in order, no gaps.
REQ-033 rst_i pulsed 1 cycle after 2 reads issued -> no rsp_valid_o ever asserted, cnt=0, req_ready_o=1 cycle after release.
REQ-034 With SRAM_REQ_SHIM_ADDR_CHECK_EN, NumWords=1000: read addr 1000 -> sram_req_o=0, response rdata 0, err 1 at Latency+1.
